// File: rtl/clock_divider_bank.sv
// Bank of programmable integer clock dividers with boundary-safe divisor updates.
// Optional phase alignment across channels: define CLKDIV_PHASE_ALIGN_EN.
module clock_divider_bank #(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 2,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                div_valid,
  output logic                div_ready,
  input  logic [CW-1:0]       div_chan,
  input  logic [WIDTH-1:0]    div_value,
  input  logic [CHANNELS-1:0] chan_en,
`ifdef CLKDIV_PHASE_ALIGN_EN
  input  logic                sync,
`endif
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] busy
);

`ifdef CLKDIV_PHASE_ALIGN_EN
  typedef enum logic [1:0] {IDLE, RUN, ALIGN} st_e;
`else
  typedef enum logic {IDLE, RUN} st_e;
`endif

  logic [WIDTH-1:0]    wr_val;
  logic                wr_acc;
  logic [CHANNELS-1:0] busy_w;

  assign wr_val = (div_value < WIDTH'(2)) ? WIDTH'(2) : div_value;
  assign wr_acc = div_valid & div_ready;
  assign busy   = busy_w;

  // Out-of-range channel indices never match, so they read as ready.
  always_comb begin
    div_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++)
      if (div_chan == CW'(i)) div_ready = !busy_w[i];
  end

`ifdef CLKDIV_PHASE_ALIGN_EN
  logic [CHANNELS-1:0] flag_w;
  logic [CHANNELS-1:0] align_w;
  logic                all_align;
  logic                sync_go;

  assign all_align = &(~flag_w | align_w);
  assign sync_go   = sync & ~|flag_w;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    st_e              st_q, st_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             busy_q, busy_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [WIDTH:0]   half;
    logic             wr_hit;
    logic             last;
`ifdef CLKDIV_PHASE_ALIGN_EN
    logic             flag_q, flag_d;

    assign flag_w[g]  = flag_q;
    assign align_w[g] = (st_q == ALIGN);
`endif

    assign wr_hit = wr_acc && (div_chan == CW'(g));
    assign last   = (cnt_q == div_q - WIDTH'(1));

    always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      div_d  = div_q;
      pend_d = pend_q;
      busy_d = busy_q;
`ifdef CLKDIV_PHASE_ALIGN_EN
      flag_d = flag_q;
`endif
      if (wr_hit) begin
        pend_d = wr_val;
        busy_d = 1'b1;
      end
      unique case (st_q)
        IDLE: begin
          cnt_d = '0;
          if (busy_q) begin
            div_d  = pend_q;
            busy_d = 1'b0;
          end
          if (chan_en[g]) st_d = RUN;
        end
        RUN: begin
          if (last) begin
            cnt_d = '0;
            if (busy_q) begin
              div_d  = pend_q;
              busy_d = 1'b0;
            end
            if (!chan_en[g]) begin
              st_d = IDLE;
`ifdef CLKDIV_PHASE_ALIGN_EN
              flag_d = 1'b0;
            end else if (flag_q) begin
              st_d = ALIGN;
`endif
            end
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
`ifdef CLKDIV_PHASE_ALIGN_EN
        ALIGN: begin
          cnt_d = '0;
          if (busy_q) begin
            div_d  = pend_q;
            busy_d = 1'b0;
          end
          if (all_align) begin
            st_d   = RUN;
            flag_d = 1'b0;
          end
        end
`endif
      endcase
`ifdef CLKDIV_PHASE_ALIGN_EN
      if (sync_go && st_q == RUN && st_d == RUN) flag_d = 1'b1;
`endif
      // High phase covers the first ceil(d/2) counts of a period.
      half   = ({1'b0, div_d} + (WIDTH+1)'(1)) >> 1;
      clk_d  = (st_d == RUN) && ({1'b0, cnt_d} < half);
      tick_d = (st_d == RUN) && (cnt_d == '0);
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        st_q   <= IDLE;
        cnt_q  <= '0;
        div_q  <= WIDTH'(RESET_DIV);
        pend_q <= '0;
        busy_q <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
`ifdef CLKDIV_PHASE_ALIGN_EN
        flag_q <= 1'b0;
`endif
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        div_q  <= div_d;
        pend_q <= pend_d;
        busy_q <= busy_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
`ifdef CLKDIV_PHASE_ALIGN_EN
        flag_q <= flag_d;
`endif
      end
    end

    assign clk_out[g] = clk_q;
    assign tick[g]    = tick_q;
    assign busy_w[g]  = busy_q;
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Scoreboard bench for clock_divider_bank (three channels, so index 3 is invalid).
// Expected per-cycle output bits are queued by the stimulus and checked by a monitor.
module tb_clock_divider_bank;
  localparam int CH = 3;
  localparam int W  = 8;
  localparam int SCLK  = 0;
  localparam int STICK = 1;
  localparam int SBUSY = 2;
  localparam int SRDY  = 3;

  logic          clock;
  logic          reset;
  logic          div_valid;
  logic          div_ready;
  logic [1:0]    div_chan;
  logic [W-1:0]  div_value;
  logic [CH-1:0] chan_en;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] tick;
  logic [CH-1:0] busy;
`ifdef CLKDIV_PHASE_ALIGN_EN
  logic          sync;
`endif

  clock_divider_bank #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .RESET_DIV(2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .div_valid(div_valid),
    .div_ready(div_ready),
    .div_chan (div_chan),
    .div_value(div_value),
    .chan_en  (chan_en),
`ifdef CLKDIV_PHASE_ALIGN_EN
    .sync     (sync),
`endif
    .clk_out  (clk_out),
    .tick     (tick),
    .busy     (busy)
  );

  typedef struct {
    int    due;
    int    sig;
    int    ch;
    logic  exp;
    string nm;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic actual(input int sig, input int ch);
    case (sig)
      SCLK:    return clk_out[ch];
      STICK:   return tick[ch];
      SBUSY:   return busy[ch];
      default: return div_ready;
    endcase
  endfunction

  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        logic a;
        a = actual(sb[i].sig, sb[i].ch);
        checks++;
        if (sb[i].due < cyc || a !== sb[i].exp) begin
          errors++;
          $display("FAIL %s ch%0d cyc %0d due %0d got %b want %b",
                   sb[i].nm, sb[i].ch, cyc, sb[i].due, a, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  function automatic void push(input int due, input int sig, input int ch,
                               input logic e, input string nm);
    exp_t t;
    t.due = due; t.sig = sig; t.ch = ch; t.exp = e; t.nm = nm;
    sb.push_back(t);
  endfunction

  function automatic void expect_seq(input int sig, input int ch,
                                     input logic [31:0] bits, input int n,
                                     input int start, input string nm);
    for (int i = 0; i < n; i++)
      push(start + i, sig, ch, bits[n-1-i], nm);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [W-1:0] v);
    div_valid = 1'b1;
    div_chan  = ch;
    div_value = v;
  endtask

  task automatic restart();
    chan_en   = '0;
    div_valid = 1'b0;
    div_chan  = '0;
    div_value = '0;
`ifdef CLKDIV_PHASE_ALIGN_EN
    sync      = 1'b0;
`endif
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    for (int c = 0; c < CH; c++) begin
      push(cyc, SCLK, c, 1'b0, "rst_clk");
      push(cyc, STICK, c, 1'b0, "rst_tick");
      push(cyc, SBUSY, c, 1'b0, "rst_busy");
    end
    push(cyc, SRDY, 0, 1'b1, "rst_ready");
  endtask

  initial begin
    int c;
    reset     = 1'b0;
    chan_en   = '0;
    div_valid = 1'b0;
    div_chan  = '0;
    div_value = '0;
`ifdef CLKDIV_PHASE_ALIGN_EN
    sync      = 1'b0;
`endif

    // Reset divisor of 2 on ch0
    restart();
    c = cyc;
    chan_en = 3'b001;
    expect_seq(SCLK, 0, 32'b1010, 4, c + 1, "d2_clk");
    expect_seq(STICK, 0, 32'b1010, 4, c + 1, "d2_tick");
    expect_seq(SCLK, 1, 32'b0000, 4, c + 1, "d2_idle_ch1");
    repeat (4) step();

    // Odd divisor 5 on ch1
    restart();
    c = cyc;
    push(c, SRDY, 0, 1'b1, "d5_ready0");
    push(c + 1, SBUSY, 1, 1'b1, "d5_busy1");
    push(c + 1, SRDY, 0, 1'b0, "d5_ready1");
    push(c + 2, SBUSY, 1, 1'b0, "d5_busy2");
    push(c + 2, SRDY, 0, 1'b1, "d5_ready2");
    expect_seq(SCLK, 1, 32'b1110011100, 10, c + 3, "d5_clk");
    expect_seq(STICK, 1, 32'b1000010000, 10, c + 3, "d5_tick");
    wr(1, 8'd5);
    step();
    div_valid = 1'b0;
    step();
    chan_en = 3'b010;
    repeat (10) step();

    // Divisor 4 -> 6 written mid-period on ch0
    restart();
    c = cyc;
    push(c + 1, SBUSY, 0, 1'b1, "upd_busy_a");
    push(c + 2, SBUSY, 0, 1'b0, "upd_busy_b");
    push(c + 4, SRDY, 0, 1'b1, "upd_ready_a");
    expect_seq(SBUSY, 0, 32'b110, 3, c + 5, "upd_busy");
    expect_seq(SRDY, 0, 32'b001, 3, c + 5, "upd_ready");
    expect_seq(SCLK, 0, 32'b1100111000111000, 16, c + 3, "upd_clk");
    expect_seq(STICK, 0, 32'b1000100000100000, 16, c + 3, "upd_tick");
    wr(0, 8'd4);
    step();
    div_valid = 1'b0;
    step();
    chan_en = 3'b001;
    step();
    step();
    wr(0, 8'd6);
    step();
    div_valid = 1'b0;
    repeat (13) step();

    // Clamp of divisor 1, plus a write to a nonexistent channel
    restart();
    c = cyc;
    push(c + 2, SRDY, 0, 1'b1, "clamp_ready");
    push(c + 3, SBUSY, 0, 1'b1, "clamp_busy_a");
    push(c + 4, SBUSY, 0, 1'b0, "clamp_busy_b");
    push(c + 4, SRDY, 0, 1'b1, "bad_ready");
    for (int k = 0; k < CH; k++) begin
      push(c + 5, SBUSY, k, 1'b0, "bad_busy");
      expect_seq(SCLK, k, 32'b101010, 6, c + 5, "clamp_clk");
    end
    expect_seq(STICK, 0, 32'b101010, 6, c + 5, "clamp_tick");
    wr(0, 8'd4);
    step();
    div_valid = 1'b0;
    step();
    wr(0, 8'd1);
    step();
    div_valid = 1'b0;
    step();
    chan_en = 3'b111;
    wr(2'd3, 8'd7);
    step();
    div_valid = 1'b0;
    repeat (5) step();

    // Disable ch2 (d=8) mid-period
    restart();
    c = cyc;
    push(c + 1, SBUSY, 2, 1'b1, "dis_busy_a");
    push(c + 2, SBUSY, 2, 1'b0, "dis_busy_b");
    expect_seq(SCLK, 2, 32'b111100000000, 12, c + 3, "dis_clk");
    expect_seq(STICK, 2, 32'b100000000000, 12, c + 3, "dis_tick");
    wr(2, 8'd8);
    step();
    div_valid = 1'b0;
    step();
    chan_en = 3'b100;
    repeat (3) step();
    chan_en = 3'b000;
    repeat (9) step();

    // Asynchronous reset during the high phase of ch1
    restart();
    c = cyc;
    expect_seq(SCLK, 1, 32'b100, 3, c + 3, "arst_clk");
    expect_seq(STICK, 1, 32'b10, 2, c + 3, "arst_tick");
    wr(1, 8'd4);
    step();
    div_valid = 1'b0;
    step();
    chan_en = 3'b010;
    step();
    step();
    reset = 1'b0;
    step();

`ifdef CLKDIV_PHASE_ALIGN_EN
    // Phase alignment of ch0 (d=4) and ch1 (d=6)
    restart();
    c = cyc;
    expect_seq(SCLK, 0, 32'b1100000011001100, 16, c + 4, "al_clk0");
    expect_seq(STICK, 0, 32'b1000000010001000, 16, c + 4, "al_tick0");
    expect_seq(SCLK, 1, 32'b111000011100011, 15, c + 5, "al_clk1");
    expect_seq(STICK, 1, 32'b100000010000010, 15, c + 5, "al_tick1");
    wr(0, 8'd4);
    step();
    wr(1, 8'd6);
    step();
    div_valid = 1'b0;
    step();
    chan_en = 3'b001;
    step();
    chan_en = 3'b011;
    step();
    step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    repeat (12) step();
`endif

    step();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_divider_bank.md
Name: clock_divider_bank

Overview:
- Bank of CHANNELS independent programmable integer clock dividers, all driven from one source clock.
- Each output is a registered divided clock, plus a one-cycle tick strobe at each rising edge.
- Divisor changes and enable/disable are applied only at period boundaries, so outputs never show short high or low phases.
- Sits between the PLL/reference clock and downstream clock muxes and gaters in the clock-generation subsystem.

Parameters:
- CHANNELS, 4, number of divider channels (>=1).
- WIDTH, 8, divisor width in bits (>=2).
- RESET_DIV, 2, divisor loaded into every channel at reset (2..2^WIDTH-1).

Ports:
- clock  in  1  source clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- div_valid  in  1  divisor write request.
- div_ready  out  1  write can be accepted for the addressed channel.
- div_chan  in  max(1,$clog2(CHANNELS))  target channel of the write.
- div_value  in  WIDTH  new divisor.
- chan_en  in  CHANNELS  per-channel run enable.
- clk_out  out  CHANNELS  divided clocks (registered).
- tick  out  CHANNELS  one-cycle pulse in the first high cycle of each clk_out period.
- busy  out  CHANNELS  channel holds a pending, not yet applied divisor.

Behaviour:
- Reset (reset=0, asynchronous):
  - clk_out=0, tick=0, busy=0, div_ready=1.
  - Every channel goes to IDLE, cnt=0, active divisor = RESET_DIV, pending slot empty.
- Per-channel state: active divisor d, counter cnt (WIDTH bits), one-entry pending slot, FSM {IDLE, RUN}.
- Write handshake:
  - A write is accepted when div_valid & div_ready.
  - div_ready = !busy[div_chan]; it is combinational on div_chan.
  - A div_chan >= CHANNELS forces div_ready=1, and the write is dropped.
  - div_value of 0 or 1 is clamped to 2 on accept.
  - An accepted write fills the pending slot, and busy goes high the next cycle.
- IDLE:
  - clk_out=0, cnt=0.
  - A pending divisor is applied on the next cycle and busy clears.
  - If chan_en=1 sampled, the next state is RUN, with clk_out=1 and tick=1 in the following cycle.
- RUN:
  - The high phase is the first ceil(d/2) cycles; the low phase is the remaining floor(d/2).
  - clk_out=1 while cnt < ceil(d/2), else 0.
  - tick=1 exactly when cnt==0.
  - cnt increments each cycle. At cnt==d-1 (period end), cnt wraps to 0.
  - At period end, a pending divisor becomes active and busy clears in the same cycle.
  - chan_en is sampled only at period end. If it is 0, the next state is IDLE.
  - A deassertion mid-period therefore completes the current period, and clk_out ends low.
- Period equals d source cycles exactly; consecutive periods never mix the old and new divisor.
- Simultaneous period end and accepted write to the same channel is impossible, because div_ready is low while busy. A write to a non-busy channel on its period-end cycle applies at the following period end.
- Reset asserted mid-period drops clk_out to 0 asynchronously. Pending writes are lost.
- Channels are fully independent; there is no phase relationship unless the optional feature is used.

Optional Feature:
- Macro: CLKDIV_PHASE_ALIGN_EN.
- When defined:
  - Adds input port sync (1 bit) and FSM state ALIGN.
  - A sync=1 pulse flags every channel currently in RUN.
  - Each flagged channel finishes its current period, then enters ALIGN with clk_out=0 and cnt=0.
  - When all flagged channels are in ALIGN, they all enter RUN in the same cycle, so their first ticks coincide.
  - A channel with chan_en=0 at its period end goes to IDLE instead and is unflagged.
  - A sync arriving while an alignment is outstanding is ignored.
- When not defined: no sync port, no ALIGN state, and behaviour is as above.

Test Plan:
- Reset check: reset low then release, with chan_en=0 -> all clk_out/tick/busy=0 and div_ready=1. Set chan_en[0]=1 -> clk_out[0] runs 1,0,1,0 (RESET_DIV=2).
- Odd divisor: write d=5 to ch1 while it is IDLE, then enable -> clk_out[1] is high 3 cycles and low 2 cycles repeating; tick[1] is high every 5th cycle.
- Mid-period update: ch0 running at d=4, write d=6 at cnt=1 -> busy[0]=1 and div_ready=0 for ch0. The current period completes at 4 cycles, then periods are 6 cycles (3 high / 3 low). busy clears at the boundary.
- Clamp and bad index: write d=0 -> period 2. Write to div_chan=CHANNELS (when CHANNELS is not a power of 2) -> accepted and no channel changes.
- Disable mid-period: ch2 at d=8, drop chan_en[2] at cnt=2 -> the period finishes (4 high, 4 low), then clk_out stays 0. Assert reset at cnt=1 on another channel -> its clk_out is 0 immediately.
- (CLKDIV_PHASE_ALIGN_EN) ch0 at d=4 and ch1 at d=6 are offset; pulse sync -> both idle low until the later period end, then tick[0] and tick[1] assert in the same cycle.
